// File: rtl/plic_arb_pkg.sv
// Shared defaults, FSM state encoding and priority-extract helper for the PLIC claim arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package plic_arb_pkg;

  localparam int IRQ_NUM_DEF    = 32;
  localparam int PRIO_WIDTH_DEF = 4;
  localparam int IRQ_WIDTH_DEF  = $clog2(IRQ_NUM_DEF);

  // Widest configuration the helper can slice from (32 sources x 8-bit priority).
  localparam int PRIO_MAX_W   = 8;
  localparam int PRIO_VEC_MAX = 32 * PRIO_MAX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    LATCH = 2'd2
  } arb_state_e;

  // Priority of source i from a packed vector of pw-bit fields; caller truncates to pw.
  function automatic logic [PRIO_MAX_W-1:0] src_prio(input logic [PRIO_VEC_MAX-1:0] vec,
                                                     input int unsigned               i,
                                                     input int unsigned               pw);
    logic [PRIO_VEC_MAX-1:0] sh;
    sh = vec >> (i * pw);
    return sh[PRIO_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: edge/level request detect, pending flop and in-service flop.
// Latency: request sets pending on the next clock; claim/complete take effect on the next clock.
// Backpressure: requests are masked while in service; edges arriving then are dropped.
module plic_gateway (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic irq_q;
  logic req;

  // Edge mode fires only on a rising edge; level mode follows the line.
  assign req = edge_mode ? (irq & ~irq_q) : irq;

  // Claim clears pending and wins over a same-cycle request; claim after complete leaves it in service.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q      <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      irq_q <= irq;
      if (claim) begin
        pending <= 1'b0;
      end else if (req && !in_service) begin
        pending <= 1'b1;
      end
      if (claim) begin
        in_service <= 1'b1;
      end else if (complete) begin
        in_service <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/plic_claim_arb.sv
// PLIC target arbiter: scans pending/enabled sources for the highest priority and serves claim/complete.
// Latency: IRQ_NUM cycles per scan (one source per cycle + latch); 1 cycle with PLIC_ARB_FAST_EN.
// Backpressure: none; claim aborts and restarts the scan, claim with no winner is a no-op.
import plic_arb_pkg::*;

module plic_claim_arb #(
  parameter int IRQ_NUM    = IRQ_NUM_DEF,
  parameter int PRIO_WIDTH = PRIO_WIDTH_DEF,
  parameter int IRQ_WIDTH  = $clog2(IRQ_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [IRQ_NUM-1:0]            irq_i,
  input  logic [IRQ_NUM-1:0]            tm_i,
  input  logic [IRQ_NUM-1:0]            ie_i,
  input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]         thold_i,
  input  logic                          clam_i,
  input  logic                          comp_i,
  input  logic [IRQ_WIDTH-1:0]          comp_id_i,
  output logic [IRQ_NUM-1:0]            ip_o,
  output logic [IRQ_WIDTH-1:0]          id_o,
  output logic                          irq_o,
  output logic                          busy_o
);

  localparam logic [IRQ_WIDTH-1:0] LAST_ID = IRQ_WIDTH'(IRQ_NUM - 1);
  localparam logic [IRQ_WIDTH-1:0] FIRST_ID = IRQ_WIDTH'(1);

  logic [IRQ_NUM-1:0]      ip;
  logic [IRQ_NUM-1:0]      in_service;
  logic [IRQ_NUM-1:0]      claim_set;
  logic [IRQ_NUM-1:0]      comp_clr;
  logic [PRIO_VEC_MAX-1:0] prio_wide;
  logic [PRIO_WIDTH-1:0]   prio_arr [IRQ_NUM];
  logic [IRQ_WIDTH-1:0]    id_q;
  logic [PRIO_WIDTH-1:0]   prio_q;
  logic                    irq_q;
  logic                    claim_vld;
  logic                    unused_ok;

  // Unpack priorities into a per-source array.
  always_comb begin
    prio_wide = '0;
    prio_wide[IRQ_NUM*PRIO_WIDTH-1:0] = prio_i;
    for (int i = 0; i < IRQ_NUM; i++) begin
      prio_arr[i] = PRIO_WIDTH'(src_prio(prio_wide, i, PRIO_WIDTH));
    end
  end

  // A claim only acts when there is a winner to hand out.
  assign claim_vld = clam_i && (id_q != '0);

  // Decode claim/complete into per-source strobes; ID 0 and out-of-range IDs match nothing.
  always_comb begin
    claim_set = '0;
    comp_clr  = '0;
    for (int i = 1; i < IRQ_NUM; i++) begin
      claim_set[i] = claim_vld && (id_q == IRQ_WIDTH'(i));
      comp_clr[i]  = comp_i && (comp_id_i == IRQ_WIDTH'(i));
    end
  end

  assign ip[0]         = 1'b0;
  assign in_service[0] = 1'b0;

  for (genvar gi = 1; gi < IRQ_NUM; gi++) begin : g_gw
    plic_gateway u_gw (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .irq        (irq_i[gi]),
      .edge_mode  (tm_i[gi]),
      .claim      (claim_set[gi]),
      .complete   (comp_clr[gi]),
      .pending    (ip[gi]),
      .in_service (in_service[gi])
    );
  end

`ifdef PLIC_ARB_FAST_EN

  logic [IRQ_WIDTH-1:0]  best_id_c;
  logic [PRIO_WIDTH-1:0] best_prio_c;

  // Full max-priority search every cycle; strict compare keeps the lowest ID on ties.
  always_comb begin
    best_id_c   = '0;
    best_prio_c = '0;
    for (int i = 1; i < IRQ_NUM; i++) begin
      if (ip[i] && ie_i[i] && (prio_arr[i] > best_prio_c)) begin
        best_id_c   = IRQ_WIDTH'(i);
        best_prio_c = prio_arr[i];
      end
    end
  end

  // Winner register refreshed every cycle; a claim zeroes it for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q   <= '0;
      prio_q <= '0;
      irq_q  <= 1'b0;
    end else if (claim_vld) begin
      id_q   <= '0;
      prio_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      id_q   <= best_id_c;
      prio_q <= best_prio_c;
      irq_q  <= (best_id_c != '0) && (best_prio_c > thold_i);
    end
  end

  assign busy_o = 1'b0;

`else

  arb_state_e            state_q, state_d;
  logic [IRQ_WIDTH-1:0]  idx_q, idx_d;
  logic [IRQ_WIDTH-1:0]  best_id_q, best_id_d;
  logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
  logic [IRQ_WIDTH-1:0]  id_d;
  logic [PRIO_WIDTH-1:0] prio_d;
  logic                  irq_d;

  // Scanner state and published winner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_ID;
      best_id_q   <= '0;
      best_prio_q <= '0;
      id_q        <= '0;
      prio_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      id_q        <= id_d;
      prio_q      <= prio_d;
      irq_q       <= irq_d;
    end
  end

  // Walk one source per cycle, publish the best at LATCH; a valid claim aborts and restarts.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_id_d   = best_id_q;
    best_prio_d = best_prio_q;
    id_d        = id_q;
    prio_d      = prio_q;
    irq_d       = irq_q;
    case (state_q)
      IDLE: begin
        state_d = SCAN;
        idx_d   = FIRST_ID;
      end
      SCAN: begin
        if (ip[idx_q] && ie_i[idx_q] && (prio_arr[idx_q] > best_prio_q)) begin
          best_id_d   = idx_q;
          best_prio_d = prio_arr[idx_q];
        end
        if (idx_q == LAST_ID) begin
          state_d = LATCH;
          idx_d   = FIRST_ID;
        end else begin
          idx_d = idx_q + FIRST_ID;
        end
      end
      LATCH: begin
        id_d        = best_id_q;
        prio_d      = best_prio_q;
        irq_d       = (best_id_q != '0) && (best_prio_q > thold_i);
        best_id_d   = '0;
        best_prio_d = '0;
        state_d     = SCAN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (claim_vld) begin
      id_d        = '0;
      prio_d      = '0;
      irq_d       = 1'b0;
      idx_d       = FIRST_ID;
      best_id_d   = '0;
      best_prio_d = '0;
      state_d     = SCAN;
    end
  end

  assign busy_o = (state_q == SCAN);

`endif

  assign ip_o  = ip;
  assign id_o  = id_q;
  assign irq_o = irq_q;

  // Source 0 inputs are architecturally ignored.
  assign unused_ok = ^{irq_i[0], tm_i[0], ie_i[0], prio_arr[0], in_service[0]};

endmodule
